idle_gen: RTL and testbench

Transmit-side idle/fill generator for the 4-lane PCIe physical layer. It sits upstream of the byte-striping and parallel-serial path and guarantees that every lane carries a symbol on every cycle: COM during alignment, upstream data when offered, IDLE fill otherwise. It also inserts a periodic COM cycle for receiver re-alignment. It produces the `valido` qualifier that the receive-side `recir_idle` block uses to route lanes to the mux path or the tester path.

---
 rtl/idle_gen_pkg.sv | 13 +
 rtl/idle_gen_period_cnt.sv | 35 +++
 rtl/idle_gen.sv | 113 +++++++++++
 tb/tb_idle_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/idle_gen_pkg.sv
// Shared PHY constants: line symbols and
// the ALIGN/RUN state encoding for tx/rx blocks.
package idle_gen_pkg;

  localparam logic [7:0] PHY_COM_SYM = 8'hBC;
  localparam logic [7:0] PHY_IDL_SYM = 8'h7C;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } phy_state_e;

endpackage

// File: rtl/idle_gen_period_cnt.sv
// Wrapping counter with enable, sync reset and
// terminal-count flag (tc high when cnt == PERIOD-1).
module period_cnt #(
  parameter int PERIOD = 4,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == W'(PERIOD - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/idle_gen.sv
// Tx idle/fill generator: COM alignment burst,
// data/IDLE fill and periodic COM insertion.
module idle_gen
  import idle_gen_pkg::*;
#(
  parameter int         COM_CYCLES = 4,
  parameter int         SKP_PERIOD = 64,
  parameter logic [7:0] COM_SYM    = PHY_COM_SYM,
  parameter logic [7:0] IDL_SYM    = PHY_IDL_SYM
) (
  input  logic       clk1f,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] valid_in,
  output logic       ready_out,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] valid_out,
  output logic       valido
);

  localparam int CW = $clog2(COM_CYCLES + 1);
  localparam int SW = $clog2(SKP_PERIOD);

  phy_state_e state_q;
  phy_state_e state_d;

  logic [CW-1:0] com_cnt;
  logic [SW-1:0] skp_cnt;
  logic          com_tc;
  logic          skp_tc;

  logic [7:0] lane_in [4];
  logic [7:0] out_d   [4];
  logic [7:0] out_q   [4];
  logic [3:0] valid_out_d;
  logic [3:0] valid_out_q;
  logic       valido_d;
  logic       valido_q;

  period_cnt #(
    .PERIOD (COM_CYCLES),
    .W      (CW)
  ) u_com_cnt (
    .clk (clk1f),
    .rst (reset),
    .en  (state_q == ST_ALIGN),
    .cnt (com_cnt),
    .tc  (com_tc)
  );

  period_cnt #(
    .PERIOD (SKP_PERIOD),
    .W      (SW)
  ) u_skp_cnt (
    .clk (clk1f),
    .rst (reset),
    .en  (state_q == ST_RUN),
    .cnt (skp_cnt),
    .tc  (skp_tc)
  );

  // Register-only decode: no input-to-ready path.
  assign ready_out = (state_q == ST_RUN) && !skp_tc;

  assign lane_in[0] = in0;
  assign lane_in[1] = in1;
  assign lane_in[2] = in2;
  assign lane_in[3] = in3;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign out_d[i] = !ready_out  ? COM_SYM :
                      valid_in[i] ? lane_in[i] : IDL_SYM;
  end

  always_comb begin
    state_d     = state_q;
    valid_out_d = 4'hF;
    valido_d    = ready_out && (valid_in != 4'h0);
    unique case (state_q)
      ST_ALIGN: if (com_tc) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_ALIGN;
    endcase
  end

  always_ff @(posedge clk1f) begin
    if (reset) begin
      state_q     <= ST_ALIGN;
      valid_out_q <= 4'h0;
      valido_q    <= 1'b0;
      for (int i = 0; i < 4; i++) out_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      valido_q    <= valido_d;
      for (int i = 0; i < 4; i++) out_q[i] <= out_d[i];
    end
  end

  assign out0      = out_q[0];
  assign out1      = out_q[1];
  assign out2      = out_q[2];
  assign out3      = out_q[3];
  assign valid_out = valid_out_q;
  assign valido    = valido_q;

endmodule

// File: tb/tb_idle_gen.sv
// Self-checking bench for idle_gen against an
// edge-count reference model of the output pattern.
module tb_idle_gen;

  localparam int         COM = 4;
  localparam int         SKP = 8;
  localparam logic [7:0] CS  = 8'hBC;
  localparam logic [7:0] IS  = 8'h7C;

  logic       clk1f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0] valid_in = '0;
  logic       ready_out;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid_out;
  logic       valido;

  int checks   = 0;
  int failures = 0;
  int m        = 0;

  idle_gen #(
    .COM_CYCLES (COM),
    .SKP_PERIOD (SKP),
    .COM_SYM    (CS),
    .IDL_SYM    (IS)
  ) dut (
    .clk1f     (clk1f),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .valid_out (valid_out),
    .valido    (valido)
  );

  always #5 clk1f = ~clk1f;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m = edges since reset release; ready once ALIGN is
  // done, except the last slot of each COM period.
  function automatic logic model_ready(input int n);
    return (n >= COM) && (((n - COM) % SKP) != SKP - 1);
  endfunction

  task automatic step(input logic r, input logic [3:0] v,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      output logic cap);
    logic       rdy;
    logic [7:0] din [4];
    logic [7:0] e   [4];
    logic [3:0] evo;
    logic       evd;
    reset = r; valid_in = v;
    in0 = a; in1 = b; in2 = c; in3 = d;
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    rdy = model_ready(m);
    chk("ready_out", {31'b0, ready_out}, {31'b0, rdy});
    if (r) begin
      for (int i = 0; i < 4; i++) e[i] = 8'h00;
      evo = 4'h0; evd = 1'b0; m = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        e[i] = !rdy ? CS : (v[i] ? din[i] : IS);
      evo = 4'hF; evd = rdy && (v != 0); m++;
    end
    cap = !r && rdy;
    @(posedge clk1f); #1;
    chk("out0", {24'b0, out0}, {24'b0, e[0]});
    chk("out1", {24'b0, out1}, {24'b0, e[1]});
    chk("out2", {24'b0, out2}, {24'b0, e[2]});
    chk("out3", {24'b0, out3}, {24'b0, e[3]});
    chk("valid_out", {28'b0, valid_out}, {28'b0, evo});
    chk("valido", {31'b0, valido}, {31'b0, evd});
  endtask

  task automatic stream(input int n, inout logic [7:0] seq);
    logic cap;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 4'hF, seq, seq + 8'd1, seq + 8'd2,
           seq + 8'd3, cap);
      if (cap) seq = seq + 8'd4;
    end
  endtask

  initial begin
    logic       cap;
    logic [7:0] seq;
    int         tries;
    reset = 1'b1;
    @(posedge clk1f); #1;
    m = 0;

    step(1'b1, 4'h0, 0, 0, 0, 0, cap);
    step(1'b1, 4'h0, 0, 0, 0, 0, cap);
    for (int k = 0; k < 6; k++)
      step(1'b0, 4'h0, 0, 0, 0, 0, cap);

    step(1'b0, 4'hF, 8'h11, 8'h22, 8'h33, 8'h44, cap);
    step(1'b0, 4'b0101, 8'hAA, 8'hBB, 8'hCC, 8'hDD, cap);
    step(1'b0, 4'h0, 0, 0, 0, 0, cap);

    step(1'b1, 4'hF, 8'h55, 8'h55, 8'h55, 8'h55, cap);
    tries = 0;
    cap = 1'b0;
    while (!cap && tries < 20) begin
      step(1'b0, 4'hF, 8'h55, 8'h55, 8'h55, 8'h55, cap);
      tries++;
    end
    chk("align_capture_bound", {31'b0, cap}, 32'd1);
    step(1'b0, 4'h0, 0, 0, 0, 0, cap);

    seq = 8'h01;
    stream(40, seq);
    step(1'b1, 4'hF, seq, seq + 8'd1, seq + 8'd2, seq + 8'd3, cap);
    stream(24, seq);

    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 59) == 0), 4'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), cap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
